// File: rtl/mem_xfer_pkg.sv
// mem_xfer_pkg: shared types and geometry for the line-transfer engine.
// A cache line is LINE_W bits moved as BEATS words of WORD_W bits each.
package mem_xfer_pkg;

  localparam int LINE_W = 128;
  localparam int WORD_W = 32;
  localparam int BEATS  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/mem_xfer_watchdog.sv
// mem_xfer_watchdog: counts stalled cycles of the current beat and flags
// expire on the TIMEOUT-th consecutive cycle without a beat completing.
// Built only when MEM_XFER_TIMEOUT_EN is defined.
module mem_xfer_watchdog
  import mem_xfer_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic count,
  input  logic clear,
  output logic expire
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt_q;

  assign expire = count && !clear && (cnt_q == CW'(TIMEOUT - 1));

  // Stall counter: restarts at every beat boundary and whenever no transfer is active.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clear || !count) begin
      cnt_q <= '0;
    end else if (!expire) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/mem_line_xfer.sv
// mem_line_xfer: moves one 128-bit L2 line to/from a 32-bit word memory as
// four beats. Strobes are held high for the whole transfer; the address and
// write word advance only after mem_ready accepts a beat.
// Optional build macro: MEM_XFER_TIMEOUT_EN adds a per-beat stall watchdog
// that aborts a hung transfer with req_err.
module mem_line_xfer
  import mem_xfer_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_r,
  input  logic              req_w,
  input  logic [31:0]       req_addr,
  input  logic [LINE_W-1:0] req_wdata,
  output logic              req_ready,
  output logic [LINE_W-1:0] req_rdata,
  output logic              req_err,
  output logic              mem_r,
  output logic              mem_w,
  output logic [31:0]       mem_addr,
  output logic [WORD_W-1:0] mem_data_out,
  input  logic [WORD_W-1:0] mem_data,
  input  logic              mem_ready
);

  state_e                     state_q;
  state_e                     state_d;
  logic [1:0]                 beat_q;
  logic                       err_q;
  logic [LINE_W-1:0]          line_q;
  logic [LINE_W-WORD_W-1:0]   wdata_q;   // upper three writeback words, shifted down per beat

  logic busy;
  logic beat_done;
  logic last_beat;
  logic abort;

  assign busy      = (state_q == RD) || (state_q == WR);
  assign beat_done = busy && mem_ready;
  assign last_beat = (beat_q == 2'(BEATS - 1));

`ifdef MEM_XFER_TIMEOUT_EN
  logic expire;

  mem_xfer_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk   (clk),
    .rst   (rst),
    .count (busy),
    .clear (beat_done),
    .expire(expire)
  );

  assign abort = expire;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign abort          = 1'b0;
`endif

  // Low nibble of the request address selects within the line and is not needed.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[3:0];

  // Outputs decode straight from registered state, so they are glitch-free and zero in reset.
  assign mem_r     = (state_q == RD);
  assign mem_w     = (state_q == WR);
  assign req_ready = (state_q == DONE);
  assign req_err   = (state_q == DONE) && err_q;
  assign req_rdata = line_q;

  // Next-state selection; a beat completing in the same cycle as expiry wins.
  always_comb begin
    // NOTE: default assignment first so every path drives state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_r && req_w)  state_d = DONE;
        else if (req_r)      state_d = RD;
        else if (req_w)      state_d = WR;
      end
      RD, WR: begin
        if (beat_done && last_beat) state_d = DONE;
        else if (!beat_done && abort) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Transfer datapath: latch the request in IDLE, then step address/data one beat at a time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      err_q        <= 1'b0;
      mem_addr     <= '0;
      mem_data_out <= '0;
      wdata_q      <= '0;
      // NOTE: the line register is plain flops, not a RAM, so it is cleared with the rest and a reset never exposes a partial line.
      line_q       <= '0;
    end else begin
      // NOTE: non-blocking throughout so every register samples pre-edge values.
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          beat_q <= '0;
          err_q  <= req_r && req_w;
          if (req_r ^ req_w) begin
            mem_addr     <= {req_addr[31:4], 4'h0};
            mem_data_out <= req_w ? req_wdata[WORD_W-1:0] : '0;
            wdata_q      <= req_wdata[LINE_W-1:WORD_W];
          end
        end
        RD, WR: begin
          if (beat_done) begin
            if (state_q == RD) line_q[{beat_q, 5'd0} +: WORD_W] <= mem_data;
            if (!last_beat) begin
              beat_q        <= beat_q + 2'd1;
              mem_addr[3:2] <= beat_q + 2'd1;
              mem_data_out  <= (state_q == WR) ? wdata_q[WORD_W-1:0] : '0;
              wdata_q       <= {{WORD_W{1'b0}}, wdata_q[LINE_W-WORD_W-1:WORD_W]};
            end
          end else if (abort) begin
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_line_xfer.sv
// tb_mem_line_xfer: randomized scoreboard bench for mem_line_xfer. A word
// memory model answers the beats; a line-level reference memory predicts
// fill data. Build with MEM_XFER_TIMEOUT_EN to exercise the watchdog.
module tb_mem_line_xfer;

  localparam int TMO = 8;

  typedef struct packed {
    logic         err;
    logic [127:0] line;
  } resp_t;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req_r = 1'b0;
  logic         req_w = 1'b0;
  logic [31:0]  req_addr = '0;
  logic [127:0] req_wdata = '0;
  logic         req_ready;
  logic [127:0] req_rdata;
  logic         req_err;
  logic         mem_r;
  logic         mem_w;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_data_out;
  logic [31:0]  mem_data = '0;
  logic         mem_ready = 1'b0;

  always #5 clk = ~clk;

  mem_line_xfer #(.TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_r       (req_r),
    .req_w       (req_w),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_ready   (req_ready),
    .req_rdata   (req_rdata),
    .req_err     (req_err),
    .mem_r       (mem_r),
    .mem_w       (mem_w),
    .mem_addr    (mem_addr),
    .mem_data_out(mem_data_out),
    .mem_data    (mem_data),
    .mem_ready   (mem_ready)
  );

  int total = 0;
  int bad   = 0;

  resp_t        exp_resps[$];
  beat_t        exp_beats[$];
  logic [31:0]  ref_mem   [logic [31:0]];   // what the line-level model says memory holds
  logic [31:0]  mem_store [logic [31:0]];   // what the DUT has actually written
  logic [127:0] last_line = '0;
  int           ready_mode = 0;             // 0 tied high, 1 every third cycle, 2 random, 3 held low

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] default_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : default_word(a);
  endfunction

  function automatic logic [31:0] store_word(input logic [31:0] a);
    return mem_store.exists(a) ? mem_store[a] : default_word(a);
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    ref_mem[a]   = v;
    mem_store[a] = v;
  endtask

  // Issue one request, queue its expected beats and completion, wait (bounded) for req_ready.
  task automatic issue(input logic r, input logic w, input logic [31:0] a,
                       input logic [127:0] wd, input int exp_lat, input bit abort,
                       input string tag);
    resp_t       e;
    beat_t       bt;
    logic [31:0] wa;
    int          cyc;
    bit          got;
    @(negedge clk);
    e.err  = (r && w) || abort;
    e.line = last_line;
    if (!e.err) begin
      for (int b = 0; b < 4; b++) begin
        wa      = {a[31:4], 2'(b), 2'b00};
        bt.wr   = w;
        bt.addr = wa;
        bt.data = w ? wd[32*b +: 32] : 32'h0;
        exp_beats.push_back(bt);
        if (w) ref_mem[wa] = wd[32*b +: 32];
        else   e.line[32*b +: 32] = ref_word(wa);
      end
      if (r) last_line = e.line;
    end
    exp_resps.push_back(e);
    req_r     = r;
    req_w     = w;
    req_addr  = a;
    req_wdata = wd;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (req_ready) got = 1'b1;
    end
    req_r = 1'b0;
    req_w = 1'b0;
    check({tag, "_completed"}, got, 1'b1);
    if (exp_lat >= 0) check({tag, "_latency"}, cyc, exp_lat);
  endtask

  // Memory model plus monitor: drives mem_ready/mem_data, checks beats and completions.
  logic         hold_pending = 1'b0;
  logic [31:0]  prev_addr = '0;
  logic [31:0]  prev_dout = '0;
  logic         prev_ready = 1'b0;
  int           phase = 0;
  beat_t        mon_beat;
  resp_t        mon_resp;

  always @(negedge clk) begin
    phase = (phase + 1) % 3;
    if (rst) begin
      case (ready_mode)
        0:       mem_ready = 1'b1;
        1:       mem_ready = (phase == 2);
        2:       mem_ready = 1'($urandom_range(0, 1));
        default: mem_ready = 1'b0;
      endcase
      mem_data = mem_r ? store_word(mem_addr) : $urandom;
      check("strobe_exclusive", mem_r & mem_w, 1'b0);
      check("err_only_with_ready", req_err & ~req_ready, 1'b0);
      if (hold_pending) begin
        check("addr_held_until_accept", mem_addr, prev_addr);
        check("wdata_held_until_accept", mem_data_out, prev_dout);
      end
      if (mem_ready && (mem_r || mem_w)) begin
        check("beat_expected", exp_beats.size() != 0, 1'b1);
        if (exp_beats.size() != 0) begin
          mon_beat = exp_beats.pop_front();
          check("beat_is_write", mem_w, mon_beat.wr);
          check("beat_addr", mem_addr, mon_beat.addr);
          if (mon_beat.wr) begin
            check("beat_wdata", mem_data_out, mon_beat.data);
            mem_store[mem_addr] = mem_data_out;
          end
        end
      end
      hold_pending = (mem_r || mem_w) && !mem_ready;
      prev_addr    = mem_addr;
      prev_dout    = mem_data_out;
      if (req_ready) begin
        check("ready_one_cycle", prev_ready, 1'b0);
        check("done_strobes_low", mem_r | mem_w, 1'b0);
        check("completion_expected", exp_resps.size() != 0, 1'b1);
        if (exp_resps.size() != 0) begin
          mon_resp = exp_resps.pop_front();
          check("req_err", req_err, mon_resp.err);
          check("req_rdata", req_rdata, mon_resp.line);
        end
      end
      prev_ready = req_ready;
    end else begin
      hold_pending = 1'b0;
      prev_ready   = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: got=running expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    logic [31:0]  a;
    logic [127:0] wd;
    int           kind;
    bit           stay;
    bit           seen;

    // Reset state.
    #3;
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_req_err", req_err, 1'b0);
    check("rst_mem_r", mem_r, 1'b0);
    check("rst_mem_w", mem_w, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_data_out", mem_data_out, 32'h0);
    check("rst_req_rdata", req_rdata, 128'h0);
    @(negedge clk);
    rst = 1'b1;

    // Directed fill: ready tied high, four-beat latency.
    ready_mode = 0;
    for (int b = 0; b < 4; b++) preload(32'h0000_1230 + 32'(4 * b), 32'h0000_00A0 + 32'(b));
    issue(1'b1, 1'b0, 32'h0000_1234, '0, 5, 1'b0, "fill_1234");
    check("fill_1234_line", req_rdata, 128'h000000A3_000000A2_000000A1_000000A0);

    // Directed writeback with mem_ready every third cycle, then read it back.
    ready_mode = 1;
    issue(1'b0, 1'b1, 32'h8000_0040, 128'h44444444_33333333_22222222_11111111, -1, 1'b0, "wb_8040");
    check("wb_keeps_fill_line", req_rdata, 128'h000000A3_000000A2_000000A1_000000A0);
    ready_mode = 0;
    issue(1'b1, 1'b0, 32'h8000_004C, '0, 5, 1'b0, "readback_8040");

    // Conflicting request: error completion with no memory traffic.
    issue(1'b1, 1'b1, 32'h0000_5550, '1, 1, 1'b0, "both_req");

    // Randomized mix over a small address pool so reads hit earlier writebacks.
    for (int i = 0; i < 40; i++) begin
      kind       = int'($urandom_range(0, 9));
      ready_mode = int'($urandom_range(0, 2));
      a          = 32'h4000_0000 | ($urandom_range(0, 7) << 4) | $urandom_range(0, 15);
      wd         = {$urandom, $urandom, $urandom, $urandom};
      if (kind == 0)     issue(1'b1, 1'b1, a, wd, 1, 1'b0, "rnd_both");
      else if (kind < 5) issue(1'b1, 1'b0, a, wd, (ready_mode == 0) ? 5 : -1, 1'b0, "rnd_read");
      else               issue(1'b0, 1'b1, a, wd, (ready_mode == 0) ? 5 : -1, 1'b0, "rnd_write");
    end

    // Reset during beat 2 of a read, then a clean read of freshly loaded data.
    ready_mode = 0;
    @(negedge clk);
    req_r    = 1'b1;
    req_addr = 32'h0000_2000;
    for (int b = 0; b < 4; b++) begin
      beat_t bt;
      bt.wr   = 1'b0;
      bt.addr = 32'h0000_2000 + 32'(4 * b);
      bt.data = 32'h0;
      exp_beats.push_back(bt);
    end
    repeat (3) @(negedge clk);
    req_r = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("midrst_mem_r", mem_r, 1'b0);
    check("midrst_mem_addr", mem_addr, 32'h0);
    check("midrst_req_ready", req_ready, 1'b0);
    check("midrst_req_rdata", req_rdata, 128'h0);
    exp_beats.delete();
    exp_resps.delete();
    last_line = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int b = 0; b < 4; b++) preload(32'h0000_2000 + 32'(4 * b), $urandom);
    issue(1'b1, 1'b0, 32'h0000_2008, '0, 5, 1'b0, "after_reset_fill");

`ifdef MEM_XFER_TIMEOUT_EN
    // Stalled read: watchdog aborts after TMO wait cycles.
    ready_mode = 3;
    issue(1'b1, 1'b0, 32'h0000_3000, '0, TMO + 1, 1'b1, "timeout_read");
    @(negedge clk);
    check("timeout_strobes_low", mem_r | mem_w, 1'b0);
    ready_mode = 0;
`else
    // Stalled read without a watchdog waits forever; recover with reset.
    ready_mode = 3;
    @(negedge clk);
    req_r    = 1'b1;
    req_addr = 32'h0000_3000;
    @(negedge clk);
    req_r = 1'b0;
    stay  = 1'b1;
    seen  = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      if (!mem_r) stay = 1'b0;
      if (req_ready) seen = 1'b1;
    end
    check("stall_mem_r_held", stay, 1'b1);
    check("stall_no_ready", seen, 1'b0);
    #2 rst = 1'b0;
    exp_beats.delete();
    exp_resps.delete();
    last_line = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    ready_mode = 0;
`endif

    issue(1'b1, 1'b0, 32'h8000_0040, '0, 5, 1'b0, "final_read");
    repeat (3) @(negedge clk);
    check("no_pending_completions", exp_resps.size(), 0);
    check("no_pending_beats", exp_beats.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
